// File: rtl/draw_pkg.sv
// Shared types and constants for the VGA draw arbiter: FSM states,
// default coordinate widths, screen limits and requester indices.
package draw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } draw_state_t;

    localparam int DEF_X_W   = 8;
    localparam int DEF_Y_W   = 7;
    localparam int DEF_C_W   = 3;
    localparam int DEF_X_MAX = 160;
    localparam int DEF_Y_MAX = 120;

    localparam int REQ_BASE  = 0;
    localparam int REQ_SHOT  = 1;
    localparam int REQ_ALIEN = 2;

endpackage

// File: rtl/vga_draw_arbiter_rr_pick.sv
// Combinational round-robin selector: searches from pointer+1 upward,
// wrapping modulo N_REQ, and reports the first requester found.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int               w_j;
    logic [IDX_W-1:0] w_jx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        w_jx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_j  = (int'(i_ptr) + k) % N_REQ;
            w_jx = IDX_W'(w_j);
            if (!o_any && i_req[w_jx]) begin
                o_any         = 1'b1;
                o_grant[w_jx] = 1'b1;
                o_idx         = w_jx;
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Arbitrates the single VGA pixel plotter between rectangle-fill requesters
// and scans the granted rectangle out one pixel per cycle with clipping.
module vga_draw_arbiter
    import draw_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int X_W   = DEF_X_W,
    parameter int Y_W   = DEF_Y_W,
    parameter int C_W   = DEF_C_W,
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_MAX = DEF_Y_MAX
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [N_REQ*X_W-1:0] i_req_x,
    input  logic [N_REQ*Y_W-1:0] i_req_y,
    input  logic [N_REQ*X_W-1:0] i_req_w,
    input  logic [N_REQ*Y_W-1:0] i_req_h,
    input  logic [N_REQ*C_W-1:0] i_req_colour,
    output logic [N_REQ-1:0]     o_grant,
    output logic [N_REQ-1:0]     o_done,
    output logic                 o_busy,
    output logic                 o_plot,
    output logic [X_W-1:0]       o_vga_x,
    output logic [Y_W-1:0]       o_vga_y,
    output logic [C_W-1:0]       o_vga_colour
);

    localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [X_W:0]     LP_X_MAX = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]     LP_Y_MAX = (Y_W+1)'(Y_MAX);

    draw_state_t      r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, r_win_idx, w_pick_idx;
    logic [N_REQ-1:0] w_pick_oh;
    logic             w_any;

    logic [X_W-1:0]   r_x, r_w, r_dx, w_sel_x, w_sel_w;
    logic [Y_W-1:0]   r_y, r_h, r_dy, w_sel_y, w_sel_h;
    logic [C_W-1:0]   r_colour, w_sel_colour;
    logic             r_last;

    logic [X_W:0]     w_sx;
    logic [Y_W:0]     w_sy;
    logic             w_on_screen, w_row_end, w_is_last, w_empty;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_w      = '0;
        w_sel_h      = '0;
        w_sel_colour = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_oh[i]) begin
                w_sel_x      = i_req_x[i*X_W +: X_W];
                w_sel_y      = i_req_y[i*Y_W +: Y_W];
                w_sel_w      = i_req_w[i*X_W +: X_W];
                w_sel_h      = i_req_h[i*Y_W +: Y_W];
                w_sel_colour = i_req_colour[i*C_W +: C_W];
            end
        end
    end

    // One extra bit on the sums so off-screen pixels never wrap back on-screen
    assign w_sx        = {1'b0, r_x} + {1'b0, r_dx};
    assign w_sy        = {1'b0, r_y} + {1'b0, r_dy};
    assign w_on_screen = (w_sx < LP_X_MAX) && (w_sy < LP_Y_MAX);
    assign w_row_end   = (r_dx == r_w - X_W'(1));
    assign w_is_last   = w_row_end && (r_dy == r_h - Y_W'(1));
    assign w_empty     = (r_w == '0) || (r_h == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = w_empty ? ST_DONE : ST_FILL;
            ST_FILL: if (r_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Control and output registers; r_last flags that the pixel on the outputs is the final one
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_ptr        <= IDX_W'(N_REQ - 1);
            r_last       <= 1'b0;
            o_grant      <= '0;
            o_done       <= '0;
            o_busy       <= 1'b0;
            o_plot       <= 1'b0;
            o_vga_x      <= '0;
            o_vga_y      <= '0;
            o_vga_colour <= '0;
        end else begin
            o_done <= '0;
            o_plot <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        o_grant <= w_pick_oh;
                        o_busy  <= 1'b1;
                    end
                end
                ST_LOAD, ST_FILL: begin
                    if (w_state_nxt == ST_FILL) begin
                        o_plot       <= w_on_screen;
                        o_vga_x      <= w_sx[X_W-1:0];
                        o_vga_y      <= w_sy[Y_W-1:0];
                        o_vga_colour <= r_colour;
                        r_last       <= w_is_last;
                    end else begin
                        o_done <= o_grant;
                        r_last <= 1'b0;
                    end
                end
                ST_DONE: begin
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                    r_ptr   <= r_win_idx;
                end
                default: ;
            endcase
        end
    end

    // Rectangle is captured on the IDLE->LOAD edge so the first pixel can issue straight out of LOAD
    always_ff @(posedge i_clk) begin
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    r_x       <= w_sel_x;
                    r_y       <= w_sel_y;
                    r_w       <= w_sel_w;
                    r_h       <= w_sel_h;
                    r_colour  <= w_sel_colour;
                    r_win_idx <= w_pick_idx;
                    r_dx      <= '0;
                    r_dy      <= '0;
                end
            end
            ST_LOAD, ST_FILL: begin
                if (w_state_nxt == ST_FILL) begin
                    if (w_row_end) begin
                        r_dx <= '0;
                        r_dy <= r_dy + Y_W'(1);
                    end else begin
                        r_dx <= r_dx + X_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Randomized self-checking bench for vga_draw_arbiter against a
// transaction-level model of arbitration order, pixel stream and timing.
module tb_vga_draw_arbiter;
    import draw_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_drv = 3'b000;
    logic [7:0]  rx[3];
    logic [6:0]  ry[3];
    logic [7:0]  rw[3];
    logic [6:0]  rh[3];
    logic [2:0]  rc[3];

    logic [2:0]  o_grant, o_done, o_vga_colour;
    logic        o_busy, o_plot;
    logic [7:0]  o_vga_x;
    logic [6:0]  o_vga_y;

    int n_chk  = 0;
    int n_fail = 0;
    int m_ptr  = 2;

    always #5 clk = ~clk;

    vga_draw_arbiter dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_req        (req_drv),
        .i_req_x      ({rx[2], rx[1], rx[0]}),
        .i_req_y      ({ry[2], ry[1], ry[0]}),
        .i_req_w      ({rw[2], rw[1], rw[0]}),
        .i_req_h      ({rh[2], rh[1], rh[0]}),
        .i_req_colour ({rc[2], rc[1], rc[0]}),
        .o_grant      (o_grant),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .o_plot       (o_plot),
        .o_vga_x      (o_vga_x),
        .o_vga_y      (o_vga_y),
        .o_vga_colour (o_vga_colour)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_next(input logic [2:0] pend, input int ptr);
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (ptr + k) % 3;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
        rx[i] = 8'(x);
        ry[i] = 7'(y);
        rw[i] = 8'(w);
        rh[i] = 7'(h);
        rc[i] = 3'(c);
    endtask

    task automatic set_rand(input int i);
        set_rect(i, $urandom_range(0, 170), $urandom_range(0, 125),
                 $urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 7));
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_drv = 3'b000;
        @(negedge clk);
        chk("rst_grant",  32'(o_grant), 0);
        chk("rst_done",   32'(o_done), 0);
        chk("rst_busy",   32'(o_busy), 0);
        chk("rst_plot",   32'(o_plot), 0);
        chk("rst_vga_x",  32'(o_vga_x), 0);
        chk("rst_vga_y",  32'(o_vga_y), 0);
        chk("rst_colour", 32'(o_vga_colour), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_done", 32'(o_done), 0);
        chk("rel_busy", 32'(o_busy), 0);
        m_ptr = 2;
    endtask

    // Serves the next requester the model expects; called on an IDLE-cycle negedge
    task automatic serve(input bit keep);
        int e, lat, sx, sy, sw, sh, sc, ex, ey;
        e   = rr_next(req_drv, m_ptr);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (o_grant == 3'b000 && lat < 40);
        chk("grant_lat", 32'(lat), 1);
        if (e < 0) e = 0;
        chk("grant", 32'(o_grant), 32'(1 << e));
        chk("load_busy", 32'(o_busy), 1);
        chk("load_plot", 32'(o_plot), 0);
        sx = int'(rx[e]); sy = int'(ry[e]); sw = int'(rw[e]); sh = int'(rh[e]); sc = int'(rc[e]);
        set_rand(e);
        for (int p = 0; p < sw * sh; p++) begin
            @(negedge clk);
            ex = sx + p % sw;
            ey = sy + p / sw;
            chk("plot",      32'(o_plot), 32'(ex < 160 && ey < 120));
            chk("vga_x",     32'(o_vga_x), 32'(ex % 256));
            chk("vga_y",     32'(o_vga_y), 32'(ey % 128));
            chk("colour",    32'(o_vga_colour), 32'(sc));
            chk("fill_done", 32'(o_done), 0);
            chk("fill_busy", 32'(o_busy), 1);
        end
        @(negedge clk);
        chk("done",      32'(o_done), 32'(1 << e));
        chk("done_plot", 32'(o_plot), 0);
        if (!keep) req_drv[e] = 1'b0;
        @(negedge clk);
        chk("idle_busy",  32'(o_busy), 0);
        chk("idle_grant", 32'(o_grant), 0);
        chk("idle_done",  32'(o_done), 0);
        m_ptr = e;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) set_rect(i, 0, 0, 0, 0, 0);

        // Single request on base
        do_reset();
        set_rect(REQ_BASE, 10, 5, 2, 2, 3'b100);
        req_drv = 3'b001;
        serve(1'b0);

        // All three from reset, then base+shot together
        do_reset();
        for (int i = 0; i < 3; i++) set_rand(i);
        req_drv = 3'b111;
        repeat (3) serve(1'b0);
        req_drv = 3'b011;
        repeat (2) serve(1'b0);

        // Zero width
        set_rect(REQ_SHOT, 30, 30, 0, 5, 2);
        req_drv = 3'b010;
        serve(1'b0);

        // Clipping at the right/bottom corner
        set_rect(REQ_ALIEN, 158, 119, 4, 1, 7);
        req_drv = 3'b100;
        serve(1'b0);

        // Reset in the middle of a 3x3 fill; pointer sits at shot beforehand
        set_rect(REQ_SHOT, 1, 1, 1, 1, 1);
        req_drv = 3'b010;
        serve(1'b0);
        set_rect(REQ_BASE, 20, 20, 3, 3, 5);
        req_drv = 3'b001;
        @(negedge clk);
        chk("mid_grant", 32'(o_grant), 1);
        repeat (3) @(negedge clk);
        chk("mid_pix3_x", 32'(o_vga_x), 22);
        do_reset();
        for (int i = 1; i < 3; i++) set_rand(i);
        req_drv = 3'b110;
        serve(1'b0);
        serve(1'b0);

        // Alien holds req across done; rectangle changes after LOAD
        set_rect(REQ_ALIEN, 40, 50, 3, 2, 6);
        req_drv = 3'b100;
        serve(1'b1);
        serve(1'b0);

        // Randomized traffic
        for (int t = 0; t < 25; t++) begin
            int keeps, adds;
            keeps = 0;
            adds  = 0;
            for (int i = 0; i < 3; i++) set_rand(i);
            req_drv = 3'($urandom_range(1, 7));
            while (req_drv != 3'b000) begin
                bit kp;
                kp = (keeps < 2) && ($urandom_range(0, 3) == 0);
                if (kp) keeps++;
                serve(kp);
                if (adds < 2 && $urandom_range(0, 3) == 0) begin
                    int i;
                    i = $urandom_range(0, 2);
                    if (!req_drv[i]) begin
                        set_rand(i);
                        req_drv[i] = 1'b1;
                        adds++;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
